// File: rtl/tstate_pkg.sv
// Shared definitions for the T-state sequencer: sequencer state encodings,
// T-state indices, per-class last-state constants and class decode helpers.
package tstate_pkg;

  // Sequencer states (kept as plain constants for legacy tools).
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  // T-state indices with special meaning.
  localparam int T0 = 0;
  localparam int T1 = 1;  // ROM fetch wait point, every instruction
  localparam int T3 = 3;  // class inputs first valid here
  localparam int T4 = 4;  // ROM operand wait point, mem class only

  // Last T-state of each instruction class.
  localparam logic [3:0] LAST_BASIC = 4'd3;
  localparam logic [3:0] LAST_MEM   = 4'd5;
  localparam logic [3:0] LAST_MUL   = 4'd10;
  localparam logic [3:0] LAST_DIV   = 4'd11;

  typedef enum logic [1:0] {
    CLS_BASIC = 2'd0,
    CLS_MEM   = 2'd1,
    CLS_MUL   = 2'd2,
    CLS_DIV   = 2'd3
  } instr_cls_e;

  // Priority decode when several class lines are high: div > mul > mem > basic.
  function automatic instr_cls_e decode_cls(input logic mem, input logic mul,
                                            input logic div);
    if (div)      return CLS_DIV;
    else if (mul) return CLS_MUL;
    else if (mem) return CLS_MEM;
    else          return CLS_BASIC;
  endfunction

  function automatic logic [3:0] last_state(input instr_cls_e cls);
    case (cls)
      CLS_MEM: return LAST_MEM;
      CLS_MUL: return LAST_MUL;
      CLS_DIV: return LAST_DIV;
      default: return LAST_BASIC;
    endcase
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Consecutive-stall counter for the T-state sequencer.
// Ports:
//   clk, reset_n  clock / async active-low reset
//   inc_i         current cycle is stalled on mem_ready
//   timeout_o     this stalled cycle is the TIMEOUT-th in a row
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc_i,
  output logic timeout_o
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] wait_cnt_q, wait_cnt_d;

  // Fires during the stalled cycle that brings the count up to LIMIT, so the
  // sequencer enters FAULT right after TIMEOUT consecutive stalled cycles.
  assign timeout_o = inc_i && ((wait_cnt_q + 8'd1) == LIMIT);

  always_comb begin
    wait_cnt_d = 8'd0;
    if (inc_i && !timeout_o) wait_cnt_d = wait_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wait_cnt_q <= 8'd0;
    else          wait_cnt_q <= wait_cnt_d;
  end

endmodule

// File: rtl/tstate_sequencer.sv
// Variable-length T-state sequencer with run/halt/single-step control,
// ROM wait-state stalls with timeout fault and a completed-instruction count.
// Ports:
//   clk, reset_n           clock / async active-low reset
//   run_req, step_req      start continuous / single-instruction execution
//   halt_req, step_mode    stop at next boundary / pause after every instruction
//   clr_fault              leave FAULT for IDLE
//   cls_mem/mul/div/hlt    decoded instruction class, valid from T3
//   mem_ready              ROM data valid, sampled in T1 and mem-class T4
//   t                      one-hot T-state, zero outside RUN
//   busy, halted, bus_err  state is RUN / PAUSE / FAULT
//   instr_done             last T-state of an instruction (combinational)
//   wait_active            current T-state is stalled (combinational)
//   instr_count            completed instructions, wrapping
module tstate_sequencer
  import tstate_pkg::*;
#(
  parameter int NUM_T   = 12,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic             step_mode,
  input  logic             clr_fault,
  input  logic             cls_mem,
  input  logic             cls_mul,
  input  logic             cls_div,
  input  logic             cls_hlt,
  input  logic             mem_ready,
  output logic [NUM_T-1:0] t,
  output logic             busy,
  output logic             halted,
  output logic             instr_done,
  output logic             wait_active,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [NUM_T-1:0] T_FIRST = {{(NUM_T-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [NUM_T-1:0] t_q, t_d;
  instr_cls_e       cls_q, cls_d;
  logic             hlt_q, hlt_d;
  logic             halt_q, halt_d;
  logic             one_shot_q, one_shot_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             halted_q, halted_d;
  logic             bus_err_q, bus_err_d;

  logic       in_run, stall, at_last, timeout, stop_after;
  instr_cls_e live_cls, cur_cls;
  logic       cur_hlt;

  // The class lines are only valid from T3 on; T3 itself uses them live and
  // later states use the copy captured at T3.
  assign live_cls = decode_cls(cls_mem, cls_mul, cls_div);
  assign cur_cls  = t_q[T3] ? live_cls : cls_q;
  assign cur_hlt  = t_q[T3] ? cls_hlt  : hlt_q;

  assign in_run  = (state_q == ST_RUN);
  assign stall   = in_run && !mem_ready &&
                   (t_q[T1] || (t_q[T4] && cls_q == CLS_MEM));
  assign at_last = in_run && t_q[last_state(cur_cls)];

  assign stop_after = halt_q || halt_req || cur_hlt || step_mode || one_shot_q;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .inc_i     (stall),
    .timeout_o (timeout)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    t_d        = t_q;
    cls_d      = cls_q;
    hlt_d      = hlt_q;
    halt_d     = halt_q;
    one_shot_d = one_shot_q;
    count_d    = count_q;

    case (state_q)
      ST_IDLE, ST_PAUSE: begin
        if (run_req) begin
          state_d    = ST_RUN;
          t_d        = T_FIRST;
          one_shot_d = 1'b0;
        end else if (step_req) begin
          state_d    = ST_RUN;
          t_d        = T_FIRST;
          one_shot_d = 1'b1;
        end
      end
      ST_RUN: begin
        halt_d = halt_q || halt_req;
        if (t_q[T3]) begin
          cls_d = live_cls;
          hlt_d = cls_hlt;
        end
        if (timeout) begin
          state_d = ST_FAULT;
          t_d     = '0;
        end else if (stall) begin
          t_d = t_q;
        end else if (at_last) begin
          count_d = count_q + 1'b1;
          if (stop_after) begin
            state_d = ST_PAUSE;
            t_d     = '0;
          end else begin
            t_d = T_FIRST;
          end
        end else begin
          t_d = t_q << 1;
        end
      end
      ST_FAULT: begin
        if (clr_fault) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        t_d     = '0;
      end
    endcase

    // A pending halt is consumed by any exit from RUN.
    if (state_d != ST_RUN) begin
      halt_d     = 1'b0;
      one_shot_d = 1'b0;
    end

    busy_d    = (state_d == ST_RUN);
    halted_d  = (state_d == ST_PAUSE);
    bus_err_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      t_q        <= '0;
      cls_q      <= CLS_BASIC;
      hlt_q      <= 1'b0;
      halt_q     <= 1'b0;
      one_shot_q <= 1'b0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q    <= state_d;
      t_q        <= t_d;
      cls_q      <= cls_d;
      hlt_q      <= hlt_d;
      halt_q     <= halt_d;
      one_shot_q <= one_shot_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign t           = t_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign bus_err     = bus_err_q;
  assign instr_count = count_q;
  assign instr_done  = at_last && !stall;
  assign wait_active = stall;

endmodule

// File: tb/tb_tstate_sequencer.sv
// Directed testbench for tstate_sequencer. A second instance with a 4-bit
// instruction counter shares the stimulus so counter wrap is reachable fast.
module tb_tstate_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0, step_mode = 1'b0;
  logic clr_fault = 1'b0;
  logic cls_mem = 1'b0, cls_mul = 1'b0, cls_div = 1'b0, cls_hlt = 1'b0;
  logic mem_ready = 1'b1;

  logic [11:0] t;
  logic        busy, halted, instr_done, wait_active, bus_err;
  logic [15:0] instr_count;

  logic [11:0] w_t;
  logic        w_busy, w_halted, w_instr_done, w_wait_active, w_bus_err;
  logic [3:0]  w_instr_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tstate_sequencer u_dut (
    .clk(clk), .reset_n(reset_n), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .step_mode(step_mode), .clr_fault(clr_fault),
    .cls_mem(cls_mem), .cls_mul(cls_mul), .cls_div(cls_div), .cls_hlt(cls_hlt),
    .mem_ready(mem_ready), .t(t), .busy(busy), .halted(halted),
    .instr_done(instr_done), .wait_active(wait_active), .bus_err(bus_err),
    .instr_count(instr_count)
  );

  tstate_sequencer #(.CNT_W(4)) u_dut_w (
    .clk(clk), .reset_n(reset_n), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .step_mode(step_mode), .clr_fault(clr_fault),
    .cls_mem(cls_mem), .cls_mul(cls_mul), .cls_div(cls_div), .cls_hlt(cls_hlt),
    .mem_ready(mem_ready), .t(w_t), .busy(w_busy), .halted(w_halted),
    .instr_done(w_instr_done), .wait_active(w_wait_active), .bus_err(w_bus_err),
    .instr_count(w_instr_count)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Walk one instruction from T0. cls_sel = {hlt, div, mul, mem}, driven
  // from T3 onward; halt_req pulses in T-state halt_at (-1 for none).
  task automatic run_instr(input int len, input logic [3:0] cls_sel,
                           input int halt_at, input string tag);
    for (int i = 0; i < len; i++) begin
      {cls_hlt, cls_div, cls_mul, cls_mem} = (i >= 3) ? cls_sel : 4'b0000;
      halt_req = (i == halt_at);
      #1;
      check({tag, "_t"}, 32'(t), 32'(1) << i);
      check({tag, "_done"}, 32'(instr_done), 32'(i == len - 1));
      tick();
    end
    {cls_hlt, cls_div, cls_mul, cls_mem} = 4'b0000;
    halt_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1;
    check("rst_t", 32'(t), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    check("rst_count", 32'(instr_count), 32'h0);
    check("rst_done", 32'(instr_done), 32'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'h0);

    // Basic instructions repeat T0..T3
    run_req = 1'b1; tick(); run_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("basic_t", 32'(t), 32'(1) << (i % 4));
      check("basic_done", 32'(instr_done), 32'(i % 4 == 3));
      tick();
    end
    check("basic_count", 32'(instr_count), 32'd2);

    // Class lengths, including precedence with all class lines high
    run_instr(6, 4'b0001, -1, "mem");
    run_instr(12, 4'b0100, -1, "div");
    run_instr(11, 4'b0010, -1, "mul");
    run_instr(12, 4'b0111, -1, "prec");
    check("class_count", 32'(instr_count), 32'd6);

    // halt_req in T1 of a mem instruction: completes at T5, then PAUSE
    run_instr(6, 4'b0001, 1, "halt");
    #1;
    check("halt_t", 32'(t), 32'h0);
    check("halt_halted", 32'(halted), 32'h1);
    check("halt_busy", 32'(busy), 32'h0);
    check("halt_count", 32'(instr_count), 32'd7);

    // Single step in step_mode
    step_mode = 1'b1;
    step_req = 1'b1; tick(); step_req = 1'b0;
    run_instr(4, 4'b0000, -1, "step");
    #1;
    check("step_halted", 32'(halted), 32'h1);
    check("step_count", 32'(instr_count), 32'd8);
    tick(); #1;
    check("step_stays_t", 32'(t), 32'h0);
    step_mode = 1'b0;

    // run_req and step_req together: continuous run
    run_req = 1'b1; step_req = 1'b1; tick(); run_req = 1'b0; step_req = 1'b0;
    run_instr(4, 4'b0000, -1, "both1");
    run_instr(4, 4'b0000, -1, "both2");
    #1;
    check("both_busy", 32'(busy), 32'h1);
    check("both_count", 32'(instr_count), 32'd10);

    // Halt opcode pauses at T3
    run_instr(4, 4'b1000, -1, "hlt");
    #1;
    check("hlt_halted", 32'(halted), 32'h1);
    check("hlt_count", 32'(instr_count), 32'd11);
    run_req = 1'b1; tick(); run_req = 1'b0;

    // 3-cycle stall in T1
    #1;
    check("stall_t0", 32'(t), 32'h1);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_t", 32'(t), 32'h2);
      check("stall_wait", 32'(wait_active), 32'h1);
      check("stall_done", 32'(instr_done), 32'h0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("stall_rel_t", 32'(t), 32'h2);
    check("stall_rel_wait", 32'(wait_active), 32'h0);
    tick(); #1;
    check("stall_t2", 32'(t), 32'h4);
    tick(); #1;
    check("stall_t3", 32'(t), 32'h8);
    check("stall_t3_done", 32'(instr_done), 32'h1);
    tick();
    check("stall_count", 32'(instr_count), 32'd12);

    // Timeout: 15 stalled cycles then FAULT
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      check("to_t", 32'(t), 32'h2);
      check("to_wait", 32'(wait_active), 32'h1);
      check("to_busy", 32'(busy), 32'h1);
      tick();
    end
    #1;
    check("fault_bus_err", 32'(bus_err), 32'h1);
    check("fault_busy", 32'(busy), 32'h0);
    check("fault_t", 32'(t), 32'h0);
    check("fault_wait", 32'(wait_active), 32'h0);
    check("fault_count", 32'(instr_count), 32'd12);
    run_req = 1'b1; tick(); run_req = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("fault_ignores_run", 32'(bus_err), 32'h1);
    clr_fault = 1'b1; run_req = 1'b1; tick(); clr_fault = 1'b0; run_req = 1'b0;
    #1;
    check("clr_bus_err", 32'(bus_err), 32'h0);
    check("clr_busy", 32'(busy), 32'h0);
    check("clr_halted", 32'(halted), 32'h0);

    // Async reset at T7 of a div instruction
    run_req = 1'b1; tick(); run_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cls_div = (i >= 3);
      tick();
    end
    #1;
    check("div_t7", 32'(t), 32'h80);
    reset_n = 1'b0;
    #1;
    check("arst_t", 32'(t), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_count", 32'(instr_count), 32'h0);
    check("arst_done", 32'(instr_done), 32'h0);
    cls_div = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Counter wrap on the 4-bit instance: 15 -> 0 after the 16th instruction
    run_req = 1'b1; tick(); run_req = 1'b0;
    repeat (60) tick();
    #1;
    check("wrap_w15", 32'(w_instr_count), 32'd15);
    check("wrap_main15", 32'(instr_count), 32'd15);
    repeat (4) tick();
    #1;
    check("wrap_w0", 32'(w_instr_count), 32'd0);
    check("wrap_main16", 32'(instr_count), 32'd16);
    check("wrap_w_busy", 32'(w_busy), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
